// File: rtl/alu_seq_ctrl.sv
// ALU control decoder plus execute stage: single-cycle ADD/SUB/AND/OR/SLT,
// iterative shift-add MUL, registered result behind a valid/ready handshake.
module alu_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ALUOp,
  input  logic [3:0]       Function,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             InValid,
  output logic             InReady,
  output logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Illegal,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;

  logic [2:0]       w_code;
  logic             w_illegal;
  logic             w_is_mul;
  logic [WIDTH-1:0] w_res;
  logic             w_accept;

  always_comb begin
    w_code    = 3'b010;
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    case (ALUOp)
      2'b10: w_code = 3'b010;
      2'b01: w_code = 3'b110;
      2'b00: begin
        case (Function)
          4'b0000: w_code = 3'b010;
          4'b0001: w_code = 3'b110;
          4'b0100: w_code = 3'b000;
          4'b0101: w_code = 3'b001;
          4'b1010: w_code = 3'b111;
          4'b1000: begin
            if (MUL_EN) begin
              w_code   = 3'b011;
              w_is_mul = 1'b1;
            end else begin
              w_illegal = 1'b1;
            end
          end
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_res = '0;
    case (w_code)
      3'b110:  w_res = A - B;
      3'b000:  w_res = A & B;
      3'b001:  w_res = A | B;
      3'b111:  w_res[0] = ($signed(A) < $signed(B));
      default: w_res = A + B;
    endcase
  end

  assign InReady  = rst_n && (r_state == S_IDLE) && (!OutValid || OutReady);
  assign w_accept = InValid && InReady;

  // MUL runs WIDTH shift-add steps, then spends one extra cycle at count 0
  // publishing the accumulator, giving WIDTH+1 cycles from accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      ALUControl <= 3'b000;
      Result     <= '0;
      Zero       <= 1'b0;
      Illegal    <= 1'b0;
      OutValid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            ALUControl <= w_code;
            Illegal    <= w_illegal;
            if (w_is_mul) begin
              r_state  <= S_MUL;
              r_mcand  <= A;
              r_mplier <= B;
              r_acc    <= '0;
              r_cnt    <= CW'(WIDTH);
              OutValid <= 1'b0;
            end else begin
              Result   <= w_res;
              Zero     <= (w_res == '0);
              OutValid <= 1'b1;
            end
          end else if (OutValid && OutReady) begin
            OutValid <= 1'b0;
          end
        end
        S_MUL: begin
          if (r_cnt != '0) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
          end else begin
            Result   <= r_acc;
            Zero     <= (r_acc == '0);
            OutValid <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: decode sweep, SLT/illegal, MUL latency,
// backpressure with same-edge drain+accept, and reset during MUL.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ALUOp;
  logic [3:0]  Function;
  logic [15:0] A;
  logic [15:0] B;
  logic        InValid;
  logic        InReady;
  logic [2:0]  ALUControl;
  logic [15:0] Result;
  logic        Zero;
  logic        Illegal;
  logic        OutValid;
  logic        OutReady;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_ctrl #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Function(Function),
    .A(A), .B(B), .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .Result(Result), .Zero(Zero),
    .Illegal(Illegal), .OutValid(OutValid), .OutReady(OutReady)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; assumes InReady is high.
  task automatic send(input logic [1:0] op, input logic [3:0] fn,
                      input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    ALUOp = op; Function = fn; A = a; B = b; InValid = 1'b1;
    @(posedge clk);
    #1;
    InValid = 1'b0;
  endtask

  task automatic check_single(input string tag, input logic [15:0] res,
                              input logic [2:0] code, input logic ill);
    chk({tag, "_valid"}, 32'(OutValid), 32'd1);
    chk({tag, "_res"}, 32'(Result), 32'(res));
    chk({tag, "_code"}, 32'(ALUControl), 32'(code));
    chk({tag, "_ill"}, 32'(Illegal), 32'(ill));
  endtask

  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp);
    int cyc;
    int rdy_hi;
    send(2'b00, 4'b1000, a, b);
    cyc = 0;
    rdy_hi = 0;
    while (!OutValid && cyc < 40) begin
      if (InReady) rdy_hi++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd17);
    chk({tag, "_inready_hi"}, 32'(rdy_hi), 32'd0);
    chk({tag, "_res"}, 32'(Result), 32'(exp));
    chk({tag, "_code"}, 32'(ALUControl), 32'b011);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; ALUOp = '0; Function = '0; A = '0; B = '0;
    InValid = 1'b0; OutReady = 1'b1;
    #1;
    chk("rst_valid", 32'(OutValid), 32'd0);
    chk("rst_res", 32'(Result), 32'd0);
    chk("rst_code", 32'(ALUControl), 32'd0);
    chk("rst_inready", 32'(InReady), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_inready", 32'(InReady), 32'd1);

    send(2'b00, 4'b0000, 16'h00F0, 16'h003C); check_single("add", 16'h012C, 3'b010, 1'b0);
    send(2'b00, 4'b0001, 16'h00F0, 16'h003C); check_single("sub", 16'h00B4, 3'b110, 1'b0);
    send(2'b00, 4'b0100, 16'h00F0, 16'h003C); check_single("and", 16'h0030, 3'b000, 1'b0);
    send(2'b00, 4'b0101, 16'h00F0, 16'h003C); check_single("or",  16'h00FC, 3'b001, 1'b0);
    send(2'b10, 4'b1111, 16'h0005, 16'h0003); check_single("ldst", 16'h0008, 3'b010, 1'b0);
    chk("ldst_zero", 32'(Zero), 32'd0);
    send(2'b01, 4'b0000, 16'h0005, 16'h0005); check_single("beq", 16'h0000, 3'b110, 1'b0);
    chk("beq_zero", 32'(Zero), 32'd1);
    send(2'b00, 4'b1010, 16'hFFFF, 16'h0001); check_single("slt", 16'h0001, 3'b111, 1'b0);
    send(2'b11, 4'b0000, 16'h0002, 16'h0003); check_single("op11", 16'h0005, 3'b010, 1'b1);
    send(2'b00, 4'b0011, 16'h0002, 16'h0003); check_single("fn0011", 16'h0005, 3'b010, 1'b1);

    run_mul("mul1", 16'h0123, 16'h0011, 16'h1353);
    run_mul("mul2", 16'hFFFF, 16'hFFFF, 16'h0001);

    // Backpressure: result 2 must hold while a queued ADD waits.
    send(2'b10, 4'b0000, 16'h0001, 16'h0001);
    @(negedge clk);
    OutReady = 1'b0;
    ALUOp = 2'b10; A = 16'd10; B = 16'd20; InValid = 1'b1;
    #1;
    chk("bp_inready0", 32'(InReady), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_inready", 32'(InReady), 32'd0);
      chk("bp_hold", {15'd0, OutValid, Result}, {15'd0, 1'b1, 16'h0002});
    end
    @(negedge clk);
    OutReady = 1'b1;
    @(posedge clk);
    #1;
    InValid = 1'b0;
    chk("drain_accept_valid", 32'(OutValid), 32'd1);
    chk("drain_accept_res", 32'(Result), 32'd30);
    @(posedge clk);
    #1;
    chk("drain_only_valid", 32'(OutValid), 32'd0);
    chk("drain_only_res", 32'(Result), 32'd30);

    // Reset asserted mid-cycle, eight cycles into a MUL.
    send(2'b00, 4'b1000, 16'h0003, 16'h0005);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(OutValid), 32'd0);
    chk("mrst_res", 32'(Result), 32'd0);
    chk("mrst_code", 32'(ALUControl), 32'd0);
    chk("mrst_inready", 32'(InReady), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_inready", 32'(InReady), 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (OutValid) pulses++;
    end
    chk("mrst_no_pulse", 32'(pulses), 32'd0);
    send(2'b10, 4'b0000, 16'h0007, 16'h0008); check_single("post_rst_add", 16'h000F, 3'b010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Parametrised successor to the combinational ALU control decoder.
- Decodes ALUOp/Function into a 3-bit ALU control code, executes the operation on WIDTH-bit operands and returns a registered result through a valid/ready handshake.
- Single-cycle ops: ADD, SUB, AND, OR, SLT. New: an iterative shift-add multiply (MUL) and an illegal-op flag.
- Sits between register-file read and write-back in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL function code decodes as illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ALUOp  input  2  00 R-type (use Function), 10 load/store add, 01 branch subtract, 11 reserved.
- Function  input  4  R-type function field.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- InValid  input  1  request valid.
- InReady  output  1  unit can accept a request this cycle.
- ALUControl  output  3  registered decoded code of the last accepted op.
- Result  output  WIDTH  registered result.
- Zero  output  1  Result == 0, registered with Result.
- Illegal  output  1  last accepted op was undefined, registered with Result.
- OutValid  output  1  Result/Zero/Illegal/ALUControl valid.
- OutReady  input  1  consumer takes the result.

Behaviour:
- Reset (async, rst_n=0): state IDLE; OutValid=0, Result=0, Zero=0, Illegal=0, ALUControl=000, internal counter/accumulators 0; InReady=0 while rst_n=0.
- Decode table:
  - ALUOp=10: ADD, code 010.
  - ALUOp=01: SUB, code 110.
  - ALUOp=00 with Function 0000: ADD, 010.
  - ALUOp=00 with Function 0001: SUB, 110.
  - ALUOp=00 with Function 0100: AND, 000.
  - ALUOp=00 with Function 0101: OR, 001.
  - ALUOp=00 with Function 1010: SLT (signed), 111.
  - ALUOp=00 with Function 1000: MUL, 011.
  - Any other Function, ALUOp=11, or MUL with MUL_EN=0: code 010, ADD performed, Illegal=1.
  - Function is don't-care when ALUOp != 00.
- Accept: transfer when InValid && InReady. InReady = (state==IDLE) && (!OutValid || OutReady).
- Single-cycle ops: result registered at the accept edge; OutValid=1 after the accept edge, i.e. latency 1 cycle.
- MUL: accept edge enters state MUL and loads multiplicand=A, multiplier=B, acc=0, count=WIDTH.
  - Each MUL cycle: if multiplier LSB=1, acc+=multiplicand; multiplicand<<=1; multiplier>>=1; count-=1.
  - When count reaches 0, load Result=acc and set OutValid. Latency WIDTH+1 cycles from accept.
  - InReady=0 throughout MUL.
  - Result is the low WIDTH bits of the unsigned product (also correct for two's-complement low half).
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, with no overflow flag. SLT gives Result = {WIDTH-1 zeros, (signed A < signed B)}.
- Output hold: while OutValid && !OutReady, Result/Zero/Illegal/ALUControl/OutValid stay stable and InReady=0.
- Same-cycle drain + accept: with OutValid && OutReady && InValid in IDLE, the old result is consumed and the new single-cycle result is loaded at the same edge, so OutValid stays 1. A MUL accepted this way clears OutValid the next cycle until it completes.
- Drain only: OutValid && OutReady && !InValid clears OutValid at the next edge. Result keeps its value.
- Reset mid-MUL: immediate abort to the reset values; no result is produced.
- State machine: IDLE -> MUL on accepting a MUL; MUL -> IDLE when count reaches 0 (result loaded on that edge). No other transitions.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> OutValid=0, Result=0, ALUControl=000, InReady=0 immediately; after release InReady=1.
- Single-cycle decode sweep, OutReady=1:
  - ALUOp=00, Function=0000/0001/0100/0101, A=0x00F0, B=0x003C -> codes 010/110/000/001, Results 0x012C/0x00B4/0x0030/0x00FC, one cycle after accept each.
  - ALUOp=10 with A=0x0005, B=0x0003 -> 0x0008.
  - ALUOp=01 with A=0x0005, B=0x0005 -> 0x0000, Zero=1.
- SLT and illegal:
  - ALUOp=00, Function=1010, A=0xFFFF, B=0x0001 -> Result=0x0001.
  - ALUOp=11 with A=2, B=3 -> Result=0x0005, Illegal=1, ALUControl=010.
  - ALUOp=00, Function=0011 -> Illegal=1.
- MUL: Function=1000, A=0x0123, B=0x0011 -> InReady=0 for 17 cycles, OutValid at cycle 17, Result=0x1353, code 011.
  - Also A=0xFFFF, B=0xFFFF -> 0x0001.
- Backpressure: hold OutReady=0 for 5 cycles with InValid=1 -> InReady=0, outputs stable. Raise OutReady with a queued ADD -> drain and accept at the same edge, OutValid continuous.
- Reset mid-MUL: assert rst_n=0 eight cycles into a MUL -> no OutValid pulse; the next ADD after release behaves normally.
